// File: rtl/writeback_regfile.sv
// Writeback stage: 16 x 32-bit register file with same-cycle read bypass,
// a flag register fed back to execute, and last-commit tracking for forwarding.
module writeback_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [3:0]  rd,
  input  logic [31:0] result,
  input  logic        is_write,
  input  logic [3:0]  nzcv,
  input  logic        flag_en,
  input  logic [3:0]  ra_addr,
  input  logic [3:0]  rb_addr,
  output logic [31:0] opr1,
  output logic [31:0] opr2,
  output logic [3:0]  nzcv_old,
  output logic [31:0] dep,
  output logic        depi,
  output logic [15:0] wr_count
);

  logic [31:0] regs_reg [16];
  logic [3:0]  nzcv_reg;
  logic [31:0] dep_reg;
  logic [3:0]  last_rd_reg;
  logic        last_vld_reg;
  logic [15:0] wr_count_reg;
  logic        commit;
  logic        flag_wr;

  assign commit  = wb_valid & is_write;
  assign flag_wr = wb_valid & flag_en;

  // Each register is cleared by reset and loaded only when it is the commit target.
  for (genvar gi = 0; gi < 16; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        regs_reg[gi] <= 32'h0;
      end else if (commit && (rd == 4'(gi))) begin
        regs_reg[gi] <= result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nzcv_reg     <= 4'h0;
      dep_reg      <= 32'h0;
      last_rd_reg  <= 4'h0;
      last_vld_reg <= 1'b0;
      wr_count_reg <= 16'h0;
    end else begin
      if (flag_wr) begin
        nzcv_reg <= nzcv;
      end
      if (commit) begin
        dep_reg      <= result;
        last_rd_reg  <= rd;
        last_vld_reg <= 1'b1;
        wr_count_reg <= wr_count_reg + 16'd1;
      end
    end
  end

  // The value being written this cycle wins over the stored copy.
  always_comb begin
    opr1 = regs_reg[ra_addr];
    opr2 = regs_reg[rb_addr];
    if (commit && (ra_addr == rd)) begin
      opr1 = result;
    end
    if (commit && (rb_addr == rd)) begin
      opr2 = result;
    end
  end

  assign depi     = last_vld_reg && (rb_addr == last_rd_reg);
  assign nzcv_old = nzcv_reg;
  assign dep      = dep_reg;
  assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: stimulus queues expected outputs,
// a monitor compares them shortly before each rising edge.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  rd = 4'h0;
  logic [31:0] result = 32'h0;
  logic        is_write = 1'b0;
  logic [3:0]  nzcv = 4'h0;
  logic        flag_en = 1'b0;
  logic [3:0]  ra_addr = 4'h0;
  logic [3:0]  rb_addr = 4'h0;
  logic [31:0] opr1, opr2, dep;
  logic [3:0]  nzcv_old;
  logic        depi;
  logic [15:0] wr_count;

  localparam int K_OPR1 = 0, K_OPR2 = 1, K_NZCV = 2, K_DEP = 3, K_DEPI = 4, K_CNT = 5;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  writeback_regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .rd       (rd),
    .result   (result),
    .is_write (is_write),
    .nzcv     (nzcv),
    .flag_en  (flag_en),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .opr1     (opr1),
    .opr2     (opr2),
    .nzcv_old (nzcv_old),
    .dep      (dep),
    .depi     (depi),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  function automatic void want(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endfunction

  // Inputs change just after the falling edge, like the execute stage.
  task automatic drive(input logic r, input logic v, input logic [3:0] d, input logic [31:0] res,
                       input logic w, input logic [3:0] nz, input logic fe,
                       input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    #1;
    rst_n = r; wb_valid = v; rd = d; result = res; is_write = w;
    nzcv = nz; flag_en = fe; ra_addr = a; rb_addr = b;
  endtask

  task automatic idle(input logic [3:0] a, input logic [3:0] b);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, a, b);
  endtask

  // Monitor: samples 3 time units after the falling edge, well before the rising edge.
  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.kind)
          K_OPR1:  act = opr1;
          K_OPR2:  act = opr2;
          K_NZCV:  act = {28'h0, nzcv_old};
          K_DEP:   act = dep;
          K_DEPI:  act = {31'h0, depi};
          default: act = {16'h0, wr_count};
        endcase
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end else begin
          $display("ok   %s: %h", e.name, act);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset held for two cycles, then every address reads zero.
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      idle(4'(i), 4'(15 - i));
      want(K_OPR1, 32'h0, $sformatf("reset_opr1_r%0d", i));
      want(K_OPR2, 32'h0, $sformatf("reset_opr2_r%0d", 15 - i));
      want(K_DEPI, 32'h0, "reset_depi");
    end
    want(K_NZCV, 32'h0, "reset_nzcv");
    want(K_DEP,  32'h0, "reset_dep");
    want(K_CNT,  32'h0, "reset_wr_count");

    // Commit with same-cycle bypass.
    drive(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 4'h0, 1'b0, 4'd3, 4'd0);
    want(K_OPR1, 32'hDEADBEEF, "bypass_opr1_r3");
    want(K_OPR2, 32'h0, "no_bypass_opr2_r0");
    want(K_CNT,  32'h0, "count_before_edge");
    idle(4'd3, 4'd3);
    want(K_OPR1, 32'hDEADBEEF, "stored_r3");
    want(K_OPR2, 32'hDEADBEEF, "stored_r3_b");
    want(K_DEP,  32'hDEADBEEF, "dep_after_commit");
    want(K_CNT,  32'd1, "count_after_commit");
    want(K_DEPI, 32'd1, "depi_r3");

    // Flags only: registers, dep and count untouched, no bypass.
    drive(1'b1, 1'b1, 4'd3, 32'h12345678, 1'b0, 4'b1000, 1'b1, 4'd3, 4'd3);
    want(K_OPR1, 32'hDEADBEEF, "flags_only_no_bypass");
    want(K_NZCV, 32'h0, "flags_before_edge");
    idle(4'd3, 4'd0);
    want(K_OPR1, 32'hDEADBEEF, "flags_only_r3_kept");
    want(K_NZCV, 32'h8, "flags_only_nzcv");
    want(K_CNT,  32'd1, "flags_only_count");
    want(K_DEP,  32'hDEADBEEF, "flags_only_dep");

    // wb_valid low: everything ignored.
    drive(1'b1, 1'b0, 4'd4, 32'h0000AAAA, 1'b1, 4'hF, 1'b1, 4'd4, 4'd4);
    want(K_OPR1, 32'h0, "invalid_no_bypass");
    idle(4'd4, 4'd0);
    want(K_OPR1, 32'h0, "invalid_r4_kept");
    want(K_NZCV, 32'h8, "invalid_nzcv_kept");
    want(K_CNT,  32'd1, "invalid_count_kept");

    // Forwarding tracks only the latest commit.
    drive(1'b1, 1'b1, 4'd5, 32'd7, 1'b1, 4'h0, 1'b0, 4'd5, 4'd0);
    want(K_OPR1, 32'd7, "bypass_r5");
    drive(1'b1, 1'b1, 4'd6, 32'd9, 1'b1, 4'h0, 1'b0, 4'd0, 4'd5);
    want(K_OPR2, 32'd7, "r5_read_during_r6_commit");
    want(K_DEPI, 32'd1, "depi_r5_before_r6_lands");
    idle(4'd0, 4'd5);
    want(K_DEPI, 32'd0, "depi_r5_superseded");
    want(K_OPR2, 32'd7, "stored_r5");
    idle(4'd0, 4'd6);
    want(K_DEPI, 32'd1, "depi_r6");
    want(K_DEP,  32'd9, "dep_r6");
    want(K_CNT,  32'd3, "count_after_r6");

    // Commit and flag update together.
    drive(1'b1, 1'b1, 4'd7, 32'h11, 1'b1, 4'b0101, 1'b1, 4'd0, 4'd7);
    want(K_OPR2, 32'h11, "bypass_r7");
    idle(4'd7, 4'd7);
    want(K_OPR1, 32'h11, "stored_r7");
    want(K_NZCV, 32'h5, "nzcv_with_commit");
    want(K_CNT,  32'd4, "count_after_r7");

    // Back-to-back commits to the same register.
    drive(1'b1, 1'b1, 4'd8, 32'hA, 1'b1, 4'h0, 1'b0, 4'd0, 4'd0);
    drive(1'b1, 1'b1, 4'd8, 32'hB, 1'b1, 4'h0, 1'b0, 4'd8, 4'd8);
    want(K_OPR1, 32'hB, "b2b_bypass_a");
    want(K_OPR2, 32'hB, "b2b_bypass_b");
    idle(4'd8, 4'd8);
    want(K_OPR1, 32'hB, "b2b_stored");
    want(K_DEP,  32'hB, "b2b_dep");
    want(K_CNT,  32'd6, "b2b_count");

    // Reset wins over a simultaneous commit and flag update, and clears prior state.
    drive(1'b0, 1'b1, 4'd2, 32'h55, 1'b1, 4'hF, 1'b1, 4'd2, 4'd2);
    idle(4'd2, 4'd2);
    want(K_OPR1, 32'h0, "rst_prio_r2");
    want(K_DEPI, 32'h0, "rst_prio_depi");
    want(K_CNT,  32'h0, "rst_prio_count");
    want(K_NZCV, 32'h0, "rst_prio_nzcv");
    want(K_DEP,  32'h0, "rst_prio_dep");
    idle(4'd3, 4'd0);
    want(K_OPR1, 32'h0, "rst_clears_r3");
    want(K_DEPI, 32'h0, "rst_depi_rb_r0");
    idle(4'd8, 4'd7);
    want(K_OPR1, 32'h0, "rst_clears_r8");
    want(K_OPR2, 32'h0, "rst_clears_r7");

    // First commit after reset, to r0 which is an ordinary register.
    drive(1'b1, 1'b1, 4'd0, 32'h1234, 1'b1, 4'h0, 1'b0, 4'd0, 4'd1);
    want(K_OPR1, 32'h1234, "post_rst_bypass_r0");
    idle(4'd1, 4'd0);
    want(K_OPR2, 32'h1234, "post_rst_r0");
    want(K_DEPI, 32'd1, "post_rst_depi");
    want(K_DEP,  32'h1234, "post_rst_dep");
    want(K_CNT,  32'd1, "post_rst_count");

    // Counter wrap: reset, 65535 commits, then one more.
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 1'b1, 4'(i), 32'(i), 1'b1, 4'h0, 1'b0, 4'h0, 4'h0);
    end
    idle(4'd14, 4'd14);
    want(K_CNT,  32'hFFFF, "preload_count");
    want(K_OPR1, 32'hFFFE, "preload_r14");
    want(K_DEP,  32'hFFFE, "preload_dep");
    want(K_DEPI, 32'd1, "preload_depi");
    drive(1'b1, 1'b1, 4'd1, 32'hCAFE, 1'b1, 4'h0, 1'b0, 4'd1, 4'd1);
    want(K_CNT,  32'hFFFF, "wrap_before_edge");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'd2, 32'hBAD, 1'b1, 4'h0, 1'b0, 4'd1, 4'd1);
      want(K_CNT,  32'h0, $sformatf("wrap_gap%0d_count", i));
      want(K_DEPI, 32'd1, $sformatf("wrap_gap%0d_depi", i));
      want(K_OPR1, 32'hCAFE, $sformatf("wrap_gap%0d_r1", i));
    end

    // Let the monitor drain; anything left over counts as a miss.
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      @(negedge clk);
      #4;
    end
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked, expected 0", q.size());
      n_bad += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge, half a cycle after the execute stage updates on the falling edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 wb_valid  input  1  execute output is valid this cycle.
REQ-005 rd  input  4  destination register index.
REQ-006 result  input  32  execute result.
REQ-007 is_write  input  1  commit result to rd when set.
REQ-008 nzcv  input  4  flags produced by execute.
REQ-009 flag_en  input  1  commit nzcv to the flag register when set.
REQ-010 ra_addr, rb_addr  input  4 each  operand read addresses.
REQ-011 opr1, opr2  output  32 each  combinational register reads of ra_addr and rb_addr.
REQ-012 nzcv_old  output  4  registered flag state, fed back to execute.
REQ-013 dep  output  32  registered copy of the most recently committed result.
REQ-014 depi  output  1  combinational: rb_addr matches the last committed rd and last_vld=1.
REQ-015 wr_count  output  16  registered count of register commits.

Function
REQ-016 Storage SHALL be 16 x 32-bit registers r0..r15, all writable, with no hard-wired zero register.
REQ-017 Commit condition SHALL be commit = wb_valid & is_write; on a rising edge with commit=1, reg[rd] <= result.
REQ-018 On commit, dep <= result, last_rd <= rd, last_vld <= 1, and wr_count <= wr_count+1, wrapping from 0xFFFF to 0x0000.
REQ-019 With wb_valid=1 and is_write=0, no register, dep, last_rd, last_vld or wr_count SHALL change.
REQ-020 With wb_valid=0, all inputs SHALL be ignored and all state SHALL hold.
REQ-021 Flag update: wb_valid & flag_en -> nzcv_old <= nzcv, independent of is_write; this covers compare-type ops that write flags only.
REQ-022 Read bypass: if commit=1 and ra_addr==rd, opr1 SHALL equal result in the same cycle; the same rule SHALL apply to opr2 and rb_addr.
REQ-023 Without a matching commit, opr1=reg[ra_addr] and opr2=reg[rb_addr]; there SHALL be no read latency.
REQ-024 depi SHALL be 1 only when last_vld=1 and rb_addr==last_rd, and 0 otherwise.
REQ-025 Any register commit, including one to a different rd, SHALL replace dep and last_rd, so depi tracks only the latest commit.
REQ-026 Back-to-back commits to the same rd on consecutive cycles SHALL leave the later value in both the register and dep.
REQ-027 Flag update and register commit in the same cycle SHALL both take effect.
REQ-028 No back-pressure SHALL exist; the block SHALL accept one commit per cycle indefinitely.

Reset
REQ-029 While rst_n=0 at a rising edge: all 16 registers, nzcv_old, dep, last_rd and wr_count SHALL be 0, and last_vld SHALL be 0, so depi=0.
REQ-030 Reset SHALL take priority over a simultaneous commit or flag update; the commit is dropped and wr_count stays 0.
REQ-031 An asserted reset in the middle of a run of commits SHALL discard all prior state with no partial retention.
REQ-032 The first commit after rst_n rises SHALL behave as a normal commit.

Verification
REQ-033 Reset check: hold rst_n=0 for 2 cycles, then read all 16 addresses -> opr1=opr2=0, nzcv_old=0, depi=0, wr_count=0.
REQ-034 Commit and bypass: wb_valid=1, is_write=1, rd=3, result=0xDEADBEEF, ra_addr=3 -> opr1=0xDEADBEEF in the same cycle; next cycle reg3=0xDEADBEEF, dep=0xDEADBEEF, wr_count=1.
REQ-035 Flags-only: wb_valid=1, is_write=0, flag_en=1, nzcv=4'b1000 -> nzcv_old=4'b1000, registers unchanged, wr_count unchanged, dep unchanged.
REQ-036 Forwarding: commit rd=5 value 7, then commit rd=6 value 9, then rb_addr=5 -> depi=0; rb_addr=6 -> depi=1, dep=9.
REQ-037 Reset priority: rst_n=0 with commit rd=2, value 0x55 -> afterwards reg2=0, wr_count=0, depi=0.
REQ-038 Counter wrap: preload with 65535 commits, then one more -> wr_count=0x0000; gaps with wb_valid=0 -> count holds.
